// File: rtl/rf_pkg.sv
// Package: rf_pkg
// Purpose : shared widths, the zero-register index, the per-operand
//           S1 record (index, forward bit, forward data) and the
//           writeback snoop compare used by every operand slot.
package rf_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 8;

    localparam logic [ADDR_W-1:0] ZERO_REG = {ADDR_W{1'b0}};

    // Operand record held while the request waits for / holds its RAM data.
    typedef struct packed {
        logic [ADDR_W-1:0] rs;
        logic              fwd_valid;
        logic [DATA_W-1:0] fwd_data;
    } operand_rec_t;

    // A writeback matches a source index unless that index is the hardwired zero register.
    function automatic logic wb_hit(input logic              wb_valid,
                                    input logic [ADDR_W-1:0] wb_rd,
                                    input logic [ADDR_W-1:0] rs);
        return wb_valid && (wb_rd == rs) && (rs != ZERO_REG);
    endfunction

endpackage

// File: rtl/rf_read_stage_if.sv
// Interface: rf_read_stage_if
// Purpose  : bundles the request, writeback, register-RAM and operand-output
//            signals of the operand-fetch stage.
//   slave  : the stage itself (takes requests/writebacks/RAM data, drives
//            RAM addresses/write port and the operand output).
//   master : the surrounding pipeline / RAM / consumer.
interface rf_read_stage_if;
    import rf_pkg::*;

    // request side
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [TAG_W-1:0]  in_tag;
    // writeback side
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    // register RAM
    logic [ADDR_W-1:0] ram_raddr1;
    logic [ADDR_W-1:0] ram_raddr2;
    logic [DATA_W-1:0] ram_rdata1;
    logic [DATA_W-1:0] ram_rdata2;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    // operand output
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op1;
    logic [DATA_W-1:0] out_op2;
    logic [TAG_W-1:0]  out_tag;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_tag,
        input  wb_valid, wb_rd, wb_data,
        input  ram_rdata1, ram_rdata2,
        input  out_ready,
        output in_ready,
        output ram_raddr1, ram_raddr2, ram_wen, ram_waddr, ram_wdata,
        output out_valid, out_op1, out_op2, out_tag
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_tag,
        output wb_valid, wb_rd, wb_data,
        output ram_rdata1, ram_rdata2,
        output out_ready,
        input  in_ready,
        input  ram_raddr1, ram_raddr2, ram_wen, ram_waddr, ram_wdata,
        input  out_valid, out_op1, out_op2, out_tag
    );

endinterface

// File: rtl/rf_operand_slot.sv
// Module : rf_operand_slot
// Purpose: one operand lane through both stage slots. Keeps the S1 record
//          (index + forward bit/data), resolves the operand value when it
//          moves to S2, and keeps the S2 value current with writebacks.
// Ports  : clk/resetn; accept loads S1 from in_rs; s1_valid/s1_adv describe
//          S1 occupancy and the S1->S2 move; wb_* is the writeback snoop;
//          ram_rdata is the RAM word due in the first S1 cycle; op is the
//          registered S2 operand.
module rf_operand_slot
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              accept,
    input  logic              s1_valid,
    input  logic              s1_adv,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] op
);

    operand_rec_t      s1_q, s1_d;
    logic [ADDR_W-1:0] s2_rs_q, s2_rs_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [DATA_W-1:0] s1_val_s;

    // Resolved S1 operand: zero reg, then a same-cycle writeback, then an earlier forward, then RAM.
    always_comb begin
        if (s1_q.rs == ZERO_REG) begin
            s1_val_s = {DATA_W{1'b0}};
        end else if (wb_hit(wb_valid, wb_rd, s1_q.rs)) begin
            s1_val_s = wb_data;
        end else if (s1_q.fwd_valid) begin
            s1_val_s = s1_q.fwd_data;
        end else begin
            s1_val_s = ram_rdata;
        end
    end

    // S1 record: load on accept; while stalled in S1 capture the resolved value,
    // because the RAM word is only valid in the first S1 cycle.
    always_comb begin
        s1_d = s1_q;
        if (accept) begin
            s1_d.rs        = in_rs;
            s1_d.fwd_valid = wb_hit(wb_valid, wb_rd, in_rs);
            s1_d.fwd_data  = wb_data;
        end else if (s1_valid && !s1_adv) begin
            s1_d.fwd_valid = 1'b1;
            s1_d.fwd_data  = s1_val_s;
        end else begin
            s1_d = s1_q;
        end
    end

    // S2 operand: take the resolved S1 value on a move, otherwise keep snooping writebacks.
    always_comb begin
        s2_rs_d = s2_rs_q;
        op_d    = op_q;
        if (s1_adv) begin
            s2_rs_d = s1_q.rs;
            op_d    = s1_val_s;
        end else if (wb_hit(wb_valid, wb_rd, s2_rs_q)) begin
            op_d = wb_data;
        end else begin
            op_d = op_q;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q    <= '{rs: ZERO_REG, fwd_valid: 1'b0, fwd_data: {DATA_W{1'b0}}};
            s2_rs_q <= ZERO_REG;
            op_q    <= {DATA_W{1'b0}};
        end else begin
            s1_q    <= s1_d;
            s2_rs_q <= s2_rs_d;
            op_q    <= op_d;
        end
    end

    assign op = op_q;

endmodule

// File: rtl/rf_read_stage.sv
// Module : rf_read_stage
// Purpose: operand-fetch stage in front of the 64x32 register RAM.
//          Accepts source indices over valid/ready, issues RAM reads, owns
//          the RAM write port, forwards in-flight writebacks, forces reg 0
//          to zero and delivers operand pairs at up to one per cycle.
// Ports  : clk, resetn (async active-low), flush (sync drop of in-flight
//          requests), bus (slave side of rf_read_stage_if: request,
//          writeback, RAM and operand-output signals).
module rf_read_stage
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    rf_read_stage_if.slave  bus
);

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             s1_adv_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             accept_load_s;
    logic             load_s2_s;

    assign s1_adv_s      = s1_valid_q && (!s2_valid_q || bus.out_ready);
    assign in_ready_s    = !s1_valid_q || s1_adv_s;
    assign accept_s      = bus.in_valid && in_ready_s;
    // A flush discards both the move and any same-cycle accept.
    assign accept_load_s = accept_s && !flush;
    assign load_s2_s     = s1_adv_s && !flush;

    // Slot occupancy and tag pipeline.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s1_tag_d   = s1_tag_q;
        out_tag_d  = out_tag_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept_s) begin
                s1_valid_d = 1'b1;
                s1_tag_d   = bus.in_tag;
            end else if (s1_adv_s) begin
                s1_valid_d = 1'b0;
            end else begin
                s1_valid_d = s1_valid_q;
            end
            if (s1_adv_s) begin
                s2_valid_d = 1'b1;
                out_tag_d  = s1_tag_q;
            end else if (bus.out_ready) begin
                s2_valid_d = 1'b0;
            end else begin
                s2_valid_d = s2_valid_q;
            end
        end
    end

    // Handshake state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_tag_q   <= {TAG_W{1'b0}};
            out_tag_q  <= {TAG_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_tag_q   <= s1_tag_d;
            out_tag_q  <= out_tag_d;
        end
    end

    rf_operand_slot u_slot1 (
        .clk       (clk),
        .resetn    (resetn),
        .accept    (accept_load_s),
        .s1_valid  (s1_valid_q),
        .s1_adv    (load_s2_s),
        .in_rs     (bus.in_rs1),
        .wb_valid  (bus.wb_valid),
        .wb_rd     (bus.wb_rd),
        .wb_data   (bus.wb_data),
        .ram_rdata (bus.ram_rdata1),
        .op        (bus.out_op1)
    );

    rf_operand_slot u_slot2 (
        .clk       (clk),
        .resetn    (resetn),
        .accept    (accept_load_s),
        .s1_valid  (s1_valid_q),
        .s1_adv    (load_s2_s),
        .in_rs     (bus.in_rs2),
        .wb_valid  (bus.wb_valid),
        .wb_rd     (bus.wb_rd),
        .wb_data   (bus.wb_data),
        .ram_rdata (bus.ram_rdata2),
        .op        (bus.out_op2)
    );

    // Reads always track the request indices; the RAM word is used only after an accept.
    assign bus.ram_raddr1 = bus.in_rs1;
    assign bus.ram_raddr2 = bus.in_rs2;
    // Writes to reg 0 never reach the RAM, and nothing is written while in reset.
    assign bus.ram_wen    = bus.wb_valid && (bus.wb_rd != ZERO_REG) && resetn;
    assign bus.ram_waddr  = bus.wb_rd;
    assign bus.ram_wdata  = bus.wb_data;

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_tag    = out_tag_q;

endmodule

// File: tb/tb_rf_read_stage.sv
module tb_rf_read_stage;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    logic flush;

    rf_read_stage_if bus();

    rf_read_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        logic [31:0] iv;
        iv = i;
        return 32'h1357_0000 ^ (iv * 32'h9E37_79B9);
    endfunction

    // ---------------- register RAM model (environment) ----------------
    logic [31:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = init_val(i);
        bus.ram_rdata1 = 32'h0;
        bus.ram_rdata2 = 32'h0;
        forever begin
            @(posedge clk);
            bus.ram_rdata1 <= mem[bus.ram_raddr1];
            bus.ram_rdata2 <= mem[bus.ram_raddr2];
            if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
        end
    end

    // ---------------- reference model: architectural regs + 2-deep FIFO ----------------
    typedef struct {
        logic [5:0] rs1;
        logic [5:0] rs2;
        logic [7:0] tag;
        int         acc;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] arch [64];
    int          cyc = 0;

    initial begin
        logic exp_ov;
        logic exp_ir;
        for (int i = 0; i < 64; i++) arch[i] = (i == 0) ? 32'h0 : init_val(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                exp_q.delete();
            end else begin
                exp_ov = (exp_q.size() == 2) || (exp_q.size() == 1 && (cyc - exp_q[0].acc) >= 2);
                exp_ir = !(exp_q.size() == 2 && !bus.out_ready);
                check("m_out_valid", 32'(bus.out_valid), 32'(exp_ov));
                check("m_in_ready", 32'(bus.in_ready), 32'(exp_ir));
                if (exp_ov && exp_q.size() > 0) begin
                    check("m_op1", bus.out_op1, arch[exp_q[0].rs1]);
                    check("m_op2", bus.out_op2, arch[exp_q[0].rs2]);
                    check("m_tag", 32'(bus.out_tag), 32'(exp_q[0].tag));
                end
                check("m_ram_wen", 32'(bus.ram_wen), 32'(bus.wb_valid && bus.wb_rd != 6'd0));
                if (bus.wb_valid && bus.wb_rd != 6'd0) begin
                    check("m_ram_waddr", 32'(bus.ram_waddr), 32'(bus.wb_rd));
                    check("m_ram_wdata", bus.ram_wdata, bus.wb_data);
                end
                check("m_raddr1", 32'(bus.ram_raddr1), 32'(bus.in_rs1));
                check("m_raddr2", 32'(bus.ram_raddr2), 32'(bus.in_rs2));
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (exp_ov && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                    if (bus.in_valid && exp_ir)
                        exp_q.push_back('{rs1: bus.in_rs1, rs2: bus.in_rs2, tag: bus.in_tag, acc: cyc});
                end
                if (bus.wb_valid && bus.wb_rd != 6'd0) arch[bus.wb_rd] = bus.wb_data;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the accept edge; expects out_valid two cycles after the accept cycle.
    task automatic wait_out(input string nm, input logic [31:0] e1, input logic [31:0] e2, input logic [7:0] et);
        int lat;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k;
                break;
            end
            step();
        end
        check({nm, "_latency"}, 32'(lat), 32'd2);
        check({nm, "_op1"}, bus.out_op1, e1);
        check({nm, "_op2"}, bus.out_op2, e2);
        check({nm, "_tag"}, 32'(bus.out_tag), 32'(et));
    endtask

    typedef struct {
        logic [5:0]  wb_rd;
        logic [31:0] wb_data;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [7:0]  tag;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vt [5];

    // ---------------- stimulus ----------------
    initial begin
        vt[0] = '{6'd5,  32'h1234_5678, 6'd5,  6'd0,  8'h11, 32'h1234_5678, 32'h0000_0000};
        vt[1] = '{6'd0,  32'hFFFF_FFFF, 6'd0,  6'd5,  8'h22, 32'h0000_0000, 32'h1234_5678};
        vt[2] = '{6'd9,  32'hCAFE_0001, 6'd9,  6'd5,  8'h33, 32'hCAFE_0001, 32'h1234_5678};
        vt[3] = '{6'd63, 32'h8000_0000, 6'd63, 6'd63, 8'h44, 32'h8000_0000, 32'h8000_0000};
        vt[4] = '{6'd1,  32'h0000_0001, 6'd1,  6'd9,  8'h55, 32'h0000_0001, 32'hCAFE_0001};

        resetn = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_rs1 = 6'd0; bus.in_rs2 = 6'd0; bus.in_tag = 8'h0;
        bus.wb_valid = 1'b1; bus.wb_rd = 6'd3; bus.wb_data = 32'h0BAD_0BAD;
        bus.out_ready = 1'b1;

        // reset state
        #2 resetn = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_op1", bus.out_op1, 32'h0);
        check("rst_out_op2", bus.out_op2, 32'h0);
        check("rst_out_tag", 32'(bus.out_tag), 32'd0);
        check("rst_ram_wen", 32'(bus.ram_wen), 32'd0);
        step();
        bus.wb_valid = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        step();

        // table: write, idle 2, read back
        for (int v = 0; v < 5; v++) begin
            bus.wb_valid = 1'b1; bus.wb_rd = vt[v].wb_rd; bus.wb_data = vt[v].wb_data;
            @(negedge clk);
            check("tbl_ram_wen", 32'(bus.ram_wen), 32'(vt[v].wb_rd != 6'd0));
            step();
            bus.wb_valid = 1'b0;
            step();
            step();
            bus.in_valid = 1'b1; bus.in_rs1 = vt[v].rs1; bus.in_rs2 = vt[v].rs2; bus.in_tag = vt[v].tag;
            @(negedge clk);
            check("tbl_in_ready", 32'(bus.in_ready), 32'd1);
            step();
            bus.in_valid = 1'b0;
            wait_out("tbl", vt[v].exp1, vt[v].exp2, vt[v].tag);
            step();
        end

        // same-edge collision: RAM r7 holds 1, accept with wb r7 in the same cycle
        bus.wb_valid = 1'b1; bus.wb_rd = 6'd7; bus.wb_data = 32'h0000_0001;
        step();
        bus.wb_valid = 1'b0;
        step();
        bus.in_valid = 1'b1; bus.in_rs1 = 6'd7; bus.in_rs2 = 6'd7; bus.in_tag = 8'h77;
        bus.wb_valid = 1'b1; bus.wb_rd = 6'd7; bus.wb_data = 32'hDEAD_BEEF;
        step();
        bus.in_valid = 1'b0; bus.wb_valid = 1'b0;
        wait_out("coll", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 8'h77);
        step();

        // stalled output keeps snooping; both slots full -> in_ready low
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_rs1 = 6'd3; bus.in_rs2 = 6'd9; bus.in_tag = 8'hA0;
        step();
        bus.in_rs1 = 6'd2; bus.in_rs2 = 6'd2; bus.in_tag = 8'hB0;
        step();
        bus.in_rs1 = 6'd4; bus.in_rs2 = 6'd4; bus.in_tag = 8'hC0;
        bus.wb_valid = 1'b1; bus.wb_rd = 6'd9; bus.wb_data = 32'hA5A5_0000;
        @(negedge clk);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_out_tag", 32'(bus.out_tag), 32'hA0);
        step();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        check("stall_snoop_op2", bus.out_op2, 32'hA5A5_0000);
        check("stall_in_ready2", 32'(bus.in_ready), 32'd0);
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();

        // 8 back-to-back requests with forwarding traffic
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                bus.in_valid = 1'b1;
                bus.in_rs1 = 6'(i + 10); bus.in_rs2 = 6'(i + 20); bus.in_tag = 8'(8'h60 + i);
                bus.wb_valid = 1'b1; bus.wb_rd = 6'(i + 11); bus.wb_data = $urandom;
            end else begin
                bus.in_valid = 1'b0;
                bus.wb_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) check("stream_in_ready", 32'(bus.in_ready), 32'd1);
            if (i >= 2) begin
                check("stream_out_valid", 32'(bus.out_valid), 32'd1);
                check("stream_tag", 32'(bus.out_tag), 32'(8'h60 + i - 2));
            end
            step();
        end
        step();

        // flush drops S1 and the same-cycle accept; the wb in the flush cycle still lands
        bus.in_valid = 1'b1; bus.in_rs1 = 6'd12; bus.in_rs2 = 6'd0; bus.in_tag = 8'h70;
        step();
        bus.in_tag = 8'h71;
        flush = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_rd = 6'd12; bus.wb_data = 32'h600D_600D;
        step();
        flush = 1'b0; bus.wb_valid = 1'b0; bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_out_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        bus.in_valid = 1'b1; bus.in_rs1 = 6'd12; bus.in_rs2 = 6'd0; bus.in_tag = 8'h72;
        step();
        bus.in_valid = 1'b0;
        wait_out("post_flush", 32'h600D_600D, 32'h0, 8'h72);
        step();

        // reset mid-stream
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_rs1 = 6'(i + 30); bus.in_rs2 = 6'(i + 40); bus.in_tag = 8'(8'h90 + i);
            if (i < 2) step();
        end
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_op1", bus.out_op1, 32'h0);
        bus.in_valid = 1'b0;
        step();
        step();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_after_out_valid", 32'(bus.out_valid), 32'd0);
            step();
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_rs1    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
            bus.in_rs2    = 6'($urandom_range(0, 7));
            bus.in_tag    = 8'($urandom_range(0, 255));
            bus.wb_valid  = ($urandom_range(0, 1) == 1);
            bus.wb_rd     = 6'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 31) == 0);
            step();
        end
        bus.in_valid = 1'b0; bus.wb_valid = 1'b0; bus.out_ready = 1'b1; flush = 1'b0;
        repeat (6) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
